// File: rtl/oflow_pkg.sv
// rtl/oflow_pkg.sv - shared helpers and constants for the overflow monitor
// Contents: clog2, channel-index width, counter saturation value.
package oflow_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Channel index width, never below one bit.
  function automatic int idx_w(input int n_ch);
    return (clog2(n_ch) < 1) ? 1 : clog2(n_ch);
  endfunction

  // Saturation value of a cnt_w-bit window counter.
  function automatic int cnt_sat(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  localparam int N_CH_DEF  = 9;
  localparam int CNT_W_DEF = 8;
  localparam int CH_IDX_W  = idx_w(N_CH_DEF);
  localparam int CNT_SAT   = cnt_sat(CNT_W_DEF);

endpackage

// File: rtl/oflow_channel.sv
// rtl/oflow_channel.sv - per-channel sticky flag, window tracker and saturating counter
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   gate_d    : delayed acquisition gate
//   oflow_in  : overflow bit for this channel
//   clr       : channel clear (already includes clear-all)
//   state     : sticky overflow flag
//   count     : windows-with-overflow counter, saturating
//   hit       : gate_d & oflow_in
module oflow_channel
  import oflow_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate_d,
  input  logic             oflow_in,
  input  logic             clr,
  output logic             state,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

  logic             state_q, state_d;
  logic             win_seen_q, win_seen_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign hit = gate_d & oflow_in;

  always_comb begin
    state_d    = state_q;
    win_seen_d = win_seen_q;
    count_d    = count_q;

    if (clr)      state_d = 1'b0;
    else if (hit) state_d = 1'b1;

    // win_seen ignores clr so a window cleared mid-way is not recounted.
    if (!gate_d)  win_seen_d = 1'b0;
    else if (hit) win_seen_d = 1'b1;

    if (clr) begin
      count_d = '0;
    end else if (hit && !win_seen_q && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= 1'b0;
      win_seen_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      win_seen_q <= win_seen_d;
      count_q    <= count_d;
    end
  end

  assign state = state_q;
  assign count = count_q;

endmodule

// File: rtl/oflow_monitor.sv
// rtl/oflow_monitor.sv - multi-channel gated sticky overflow monitor
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   oflow_in      : per-channel overflow bits from the ADC path
//   gate          : acquisition window, delayed GATE_DLY cycles internally
//   oflow_clr     : per-channel clear of flag and counter
//   oflow_clr_all : clear of all flags, counters and first-channel capture
//   oflow_state   : sticky per-channel flags
//   oflow_any     : registered OR of flags, coincident with oflow_state
//   oflow_count   : channel k counter at [k*CNT_W +: CNT_W]
//   first_ch      : lowest-index channel of the first hit cycle
//   first_valid   : first_ch holds a captured value
module oflow_monitor
  import oflow_pkg::*;
#(
  parameter  int N_CH     = 9,
  parameter  int CNT_W    = 8,
  parameter  int GATE_DLY = 2,
  localparam int IDX_W    = idx_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       oflow_in,
  input  logic                  gate,
  input  logic [N_CH-1:0]       oflow_clr,
  input  logic                  oflow_clr_all,
  output logic [N_CH-1:0]       oflow_state,
  output logic                  oflow_any,
  output logic [N_CH*CNT_W-1:0] oflow_count,
  output logic [IDX_W-1:0]      first_ch,
  output logic                  first_valid
);

  logic [GATE_DLY-1:0] gate_pipe_q, gate_pipe_d;
  logic                gate_d;
  logic [N_CH-1:0]     hit;
  logic [N_CH-1:0]     clr_eff;
  logic                oflow_any_q, oflow_any_d;
  logic [IDX_W-1:0]    first_ch_q, first_ch_d;
  logic                first_valid_q, first_valid_d;
  logic [IDX_W-1:0]    low_idx;

  always_comb begin
    gate_pipe_d    = gate_pipe_q;
    gate_pipe_d[0] = gate;
    for (int i = 1; i < GATE_DLY; i++) begin
      gate_pipe_d[i] = gate_pipe_q[i-1];
    end
  end

  assign gate_d  = gate_pipe_q[GATE_DLY-1];
  assign clr_eff = oflow_clr | {N_CH{oflow_clr_all}};

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    oflow_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .gate_d  (gate_d),
      .oflow_in(oflow_in[k]),
      .clr     (clr_eff[k]),
      .state   (oflow_state[k]),
      .count   (oflow_count[k*CNT_W +: CNT_W]),
      .hit     (hit[k])
    );
  end

  // Lowest-index hit wins: scan downwards so the last assignment is the lowest.
  always_comb begin
    low_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (hit[k]) low_idx = IDX_W'(k);
    end
  end

  always_comb begin
    first_ch_d    = first_ch_q;
    first_valid_d = first_valid_q;
    if (oflow_clr_all) begin
      first_ch_d    = '0;
      first_valid_d = 1'b0;
    end else if (!first_valid_q && (|hit)) begin
      first_ch_d    = low_idx;
      first_valid_d = 1'b1;
    end
  end

  // Mirrors the per-channel next-state so oflow_any lands with oflow_state.
  assign oflow_any_d = |((oflow_state | hit) & ~clr_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_pipe_q   <= '0;
      oflow_any_q   <= 1'b0;
      first_ch_q    <= '0;
      first_valid_q <= 1'b0;
    end else begin
      gate_pipe_q   <= gate_pipe_d;
      oflow_any_q   <= oflow_any_d;
      first_ch_q    <= first_ch_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign oflow_any   = oflow_any_q;
  assign first_ch    = first_ch_q;
  assign first_valid = first_valid_q;

endmodule

// File: doc/oflow_monitor.md
# oflow_monitor

Multi-channel, parametrised successor to the single-bit overflow latch. It delays the acquisition gate through a configurable pipeline, then latches a sticky overflow flag per ADC channel while the delayed gate is open. It also counts the gate windows in which each channel overflowed, with saturation, and records which channel overflowed first. It sits between the ADC sample path and the register or readback block, which polls the flags and issues clears.

## Interface
Parameters:
- N_CH, 9, number of monitored channels (1..32)
- CNT_W, 8, width of each per-channel window counter (2..16)
- GATE_DLY, 2, gate pipeline depth in clk cycles (1..8); aligns gate with the ADC data latency

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- oflow_in  in  N_CH  per-channel overflow bit from the ADC path
- gate  in  1  acquisition window, level-sensitive
- oflow_clr  in  N_CH  per-channel clear of flag and counter
- oflow_clr_all  in  1  clears all flags, counters and the first-channel capture
- oflow_state  out  N_CH  sticky per-channel flags
- oflow_any  out  1  OR of oflow_state, registered
- oflow_count  out  N_CH*CNT_W  window counters; channel k occupies bits [k*CNT_W +: CNT_W]
- first_ch  out  clog2(N_CH) (min 1)  index of the first channel to overflow
- first_valid  out  1  first_ch holds a captured value

## Operation
- Gate pipeline: gate_d = gate delayed GATE_DLY registers; the pipeline is zeroed on reset.
- hit[k] = gate_d & oflow_in[k].
- Flag for channel k:
  - sets on hit[k];
  - clears on oflow_clr[k] or oflow_clr_all;
  - clear has priority over set in the same cycle;
  - otherwise the flag holds. Outside the gate it holds.
- Window tracking: per-channel win_seen[k] is set on hit[k] and cleared on the cycle gate_d is low.
  - The counter increments on the cycle hit[k] & ~win_seen[k]. This gives at most one increment per window, however many overflow cycles occur.
  - The counter saturates at 2^CNT_W-1; it never wraps.
  - Counter clear has priority over increment.
  - A clear mid-window resets the counter but not win_seen, so that window is not recounted.
- First-channel capture:
  - While first_valid=0, the first cycle with any hit loads first_ch with the lowest-index channel whose hit is set, and sets first_valid.
  - It is held until oflow_clr_all. Per-channel clears do not affect it.
  - If oflow_clr_all and a hit occur in the same cycle, the clear wins and nothing is captured.
- oflow_any = registered OR of the next-state flags, so it is coincident with oflow_state.
- Reset: all outputs 0, win_seen 0, gate pipeline 0. Reset mid-window discards the window.

## Timing
- gate rises at cycle t → gate_d high at t+GATE_DLY.
- hit at cycle t → oflow_state[k], oflow_any, count increment, first_ch and first_valid are all visible at t+1.
- Clear asserted at cycle t → outputs zero at t+1.
- No handshake. Clears are single-cycle pulses; a held clear keeps the state cleared.
- Single clock domain. oflow_in and gate are already synchronous to clk.

## Structure
- Package oflow_pkg holds:
  - function clog2;
  - localparam CH_IDX_W = max(1, clog2(N_CH));
  - the counter saturation constant, computed from CNT_W.
- Sub-module oflow_channel (one instance per channel) contains the flag, win_seen and saturating counter. It takes gate_d, oflow_in, clr (already ORed with clr_all), and outputs state, count and hit.
- The top level holds the gate pipeline, the generate loop, the priority encoder for first_ch, and oflow_any.

## Test plan
- Defaults. gate held high from cycle 0, oflow_in[3] pulsed at cycle 10:
  - oflow_state=0x008 at cycle 11, not earlier;
  - count[3]=1, first_ch=3, first_valid=1.
- Gate alignment. gate pulsed high cycles 20–24, oflow_in[0] high only at cycle 21:
  - no flag (gate_d is open cycles 22–26);
  - oflow_in[0] at cycle 22 → flag set at 23.
- One increment per window. Three windows, channel 5 overflows 4 cycles in each:
  - count[5]=3;
  - with CNT_W=2 and 5 windows, count saturates at 3.
- Clear versus set. oflow_clr[2] and hit[2] in the same cycle:
  - flag and count are 0 next cycle;
  - the hit in the following cycle sets the flag but gives no count increment within the same window.
- Simultaneous first. hit on channels 7 and 4 in the same cycle:
  - first_ch=4;
  - a later hit on channel 1 leaves first_ch=4;
  - oflow_clr_all → first_valid=0 and all zeros next cycle.
- Reset mid-window. rst asserted during an open gate with flags set:
  - all outputs 0 next cycle;
  - oflow_in held high with gate now low → no flag until a new gate_d window opens.
